// File: rtl/cpu_control_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath and memories.
// master is the sequencer side, slave is the datapath/memory side.
interface cpu_control_sequencer_if #(
   parameter int INSTRET_WIDTH = 32
);
   logic [6:0]               opcode;
   logic [2:0]               funct3;
   logic                     branch_taken;
   logic                     imem_ready;
   logic                     dmem_ready;
   logic                     imem_req;
   logic                     ir_write;
   logic                     dmem_req;
   logic                     dmem_write;
   logic                     reg_write;
   logic                     alu_select;
   logic                     result_select;
   logic                     pc_write;
   logic                     pc_select;
   logic                     instr_retired;
   logic [INSTRET_WIDTH-1:0] instret;
   logic                     trap;
   logic [1:0]               trap_cause;

   modport master (
      input  opcode, funct3, branch_taken, imem_ready, dmem_ready,
      output imem_req, ir_write, dmem_req, dmem_write, reg_write, alu_select,
             result_select, pc_write, pc_select, instr_retired, instret, trap, trap_cause
   );

   modport slave (
      output opcode, funct3, branch_taken, imem_ready, dmem_ready,
      input  imem_req, ir_write, dmem_req, dmem_write, reg_write, alu_select,
             result_select, pc_write, pc_select, instr_retired, instret, trap, trap_cause
   );
endinterface

// File: rtl/cpu_control_sequencer.sv
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer: 3-5 cycles per instruction, plus one per memory wait cycle.
// Holds requests until imem_ready/dmem_ready; a wait of MEM_TIMEOUT cycles (0 = never) lands in a sticky trap.
module cpu_control_sequencer #(
   parameter int MEM_TIMEOUT   = 255,
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cpu_control_sequencer_if.master bus
);
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam int         WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
   } state_t;

   state_t                   state, state_nxt;
   logic [WAIT_W-1:0]        wait_cnt;
   logic                     wait_inc;
   logic [1:0]               cause_q, cause_nxt;
   logic                     trap_q;
   logic [INSTRET_WIDTH-1:0] instret_q;
   logic                     retire;
   logic                     is_load, is_store, is_op_imm, is_op, is_branch, is_legal, uses_imm;
   logic                     timed_out;

   assign is_load   = (bus.opcode == OPC_LOAD)  && (bus.funct3 == F3_WORD);
   assign is_store  = (bus.opcode == OPC_STORE) && (bus.funct3 == F3_WORD);
   assign is_op_imm = (bus.opcode == OPC_OP_IMM);
   assign is_op     = (bus.opcode == OPC_OP);
   assign is_branch = (bus.opcode == OPC_BRANCH);
   assign is_legal  = is_load || is_store || is_op_imm || is_op || is_branch;
   assign uses_imm  = is_load || is_store || is_op_imm;
   assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

   always_comb begin
      state_nxt         = state;
      cause_nxt         = cause_q;
      wait_inc          = 1'b0;
      retire            = 1'b0;
      bus.imem_req      = 1'b0;
      bus.ir_write      = 1'b0;
      bus.dmem_req      = 1'b0;
      bus.dmem_write    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_select    = 1'b0;
      bus.result_select = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_select     = 1'b0;
      case (state)
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_write = 1'b1;
               state_nxt    = S_DECODE;
            end else if (timed_out) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'd2;
            end else begin
               wait_inc = (MEM_TIMEOUT != 0);
            end
         end
         S_DECODE: begin
            if (is_legal) begin
               state_nxt = S_EXECUTE;
            end else begin
               state_nxt = S_TRAP;
               cause_nxt = 2'd1;
            end
         end
         S_EXECUTE: begin
            bus.alu_select = uses_imm;
            if (is_op || is_op_imm) begin
               state_nxt = S_WRITEBACK;
            end else if (is_load || is_store) begin
               state_nxt = S_MEMORY;
            end else if (is_branch) begin
               bus.pc_write  = 1'b1;
               bus.pc_select = bus.branch_taken;
               retire        = 1'b1;
               state_nxt     = S_FETCH;
            end else begin
               // Instruction register changed under us after DECODE.
               state_nxt = S_TRAP;
               cause_nxt = 2'd1;
            end
         end
         S_MEMORY: begin
            bus.dmem_req   = 1'b1;
            bus.alu_select = 1'b1;
            bus.dmem_write = is_store;
            if (bus.dmem_ready) begin
               if (is_store) begin
                  bus.pc_write = 1'b1;
                  retire       = 1'b1;
                  state_nxt    = S_FETCH;
               end else begin
                  state_nxt = S_WRITEBACK;
               end
            end else if (timed_out) begin
               state_nxt = S_TRAP;
               cause_nxt = 2'd3;
            end else begin
               wait_inc = (MEM_TIMEOUT != 0);
            end
         end
         S_WRITEBACK: begin
            bus.reg_write     = 1'b1;
            bus.pc_write      = 1'b1;
            bus.alu_select    = uses_imm;
            bus.result_select = is_load;
            retire            = 1'b1;
            state_nxt         = S_FETCH;
         end
         S_TRAP: begin
            state_nxt = S_TRAP;
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase
      // Reset kills every enable combinationally so an aborted instruction writes nothing.
      if (!rst_n) begin
         retire            = 1'b0;
         bus.imem_req      = 1'b0;
         bus.ir_write      = 1'b0;
         bus.dmem_req      = 1'b0;
         bus.dmem_write    = 1'b0;
         bus.reg_write     = 1'b0;
         bus.alu_select    = 1'b0;
         bus.result_select = 1'b0;
         bus.pc_write      = 1'b0;
         bus.pc_select     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         cause_q   <= 2'd0;
         trap_q    <= 1'b0;
         instret_q <= '0;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (wait_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state_nxt == S_TRAP) begin
            trap_q <= 1'b1;
         end
         if (retire) begin
            instret_q <= instret_q + 1'b1;
         end
      end
   end

   assign bus.instr_retired = retire;
   assign bus.instret       = instret_q;
   assign bus.trap          = trap_q;
   assign bus.trap_cause    = cause_q;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: per-cycle stimulus and expected control vectors are queued together,
// then replayed and compared one cycle at a time.
module tb_cpu_control_sequencer;
   localparam int IW  = 4;
   localparam int TMO = 4;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic       imem_ready;
      logic       dmem_ready;
      logic       branch_taken;
      logic [6:0] opcode;
      logic [2:0] funct3;
   } stim_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   cpu_control_sequencer_if #(.INSTRET_WIDTH(IW)) bus ();

   cpu_control_sequencer #(.MEM_TIMEOUT(TMO), .INSTRET_WIDTH(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   stim_t         stim_q[$];
   logic [9:0]    exp_q[$];
   int            total = 0;
   int            bad   = 0;
   logic [IW-1:0] model_instret = '0;

   // {imem_req, ir_write, dmem_req, dmem_write, reg_write, alu_select, result_select, pc_write, pc_select, instr_retired}
   function automatic logic [9:0] ctl();
      return {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_write, bus.reg_write,
              bus.alu_select, bus.result_select, bus.pc_write, bus.pc_select, bus.instr_retired};
   endfunction

   task automatic push(input logic im, input logic dm, input logic bt, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [9:0] exp);
      stim_t s;
      s = {im, dm, bt, opc, f3};
      stim_q.push_back(s);
      exp_q.push_back(exp);
      if (exp[0]) model_instret = model_instret + 1'b1;
   endtask

   // Expected per-cycle vectors of one legal instruction, from the cycle tables of the sequencer.
   task automatic push_instr(input logic [6:0] opc, input logic [2:0] f3, input logic bt,
                             input int fwait, input int dwait);
      logic imm, mem, st;
      imm = (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_OP_IMM);
      mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
      st  = (opc == OPC_STORE);
      for (int i = 0; i < fwait; i++) push(1'b0, 1'b0, bt, opc, f3, 10'b1000000000);
      push(1'b1, 1'b0, bt, opc, f3, 10'b1100000000);
      push(1'b0, 1'b0, bt, opc, f3, 10'b0000000000);
      if (opc == OPC_BRANCH) push(1'b0, 1'b0, bt, opc, f3, {7'b0000000, 1'b1, bt, 1'b1});
      else push(1'b0, 1'b0, bt, opc, f3, {5'b00000, imm, 4'b0000});
      if (mem) begin
         for (int i = 0; i < dwait; i++) push(1'b0, 1'b0, bt, opc, f3, {2'b00, 1'b1, st, 1'b0, 1'b1, 4'b0000});
         if (st) begin
            push(1'b0, 1'b1, bt, opc, f3, 10'b0011010101);
         end else begin
            push(1'b0, 1'b1, bt, opc, f3, 10'b0010010000);
            push(1'b0, 1'b0, bt, opc, f3, 10'b0000111101);
         end
      end else if (opc != OPC_BRANCH) begin
         push(1'b0, 1'b0, bt, opc, f3, {4'b0000, 1'b1, imm, 1'b0, 1'b1, 1'b0, 1'b1});
      end
   endtask

   // Applies the next queued stimulus, samples at the falling edge, returns after the next rising edge.
   task automatic next_cycle(output logic [9:0] got, output logic [9:0] exp);
      stim_t s;
      s = stim_q.pop_front();
      bus.imem_ready   = s.imem_ready;
      bus.dmem_ready   = s.dmem_ready;
      bus.branch_taken = s.branch_taken;
      bus.opcode       = s.opcode;
      bus.funct3       = s.funct3;
      @(negedge clk);
      got = ctl();
      exp = exp_q.pop_front();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      stim_q.delete();
      exp_q.delete();
      model_instret    = '0;
      bus.imem_ready   = 1'b0;
      bus.dmem_ready   = 1'b0;
      bus.branch_taken = 1'b0;
      bus.opcode       = 7'd0;
      bus.funct3       = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #1;
      rst_n            = 1'b0;
      bus.imem_ready   = 1'b1;
      bus.dmem_ready   = 1'b1;
      bus.branch_taken = 1'b1;
      bus.opcode       = OPC_OP;
      bus.funct3       = 3'd0;
      @(negedge clk);
      total++;
      if (ctl() !== 10'd0) begin bad++; $display("FAIL reset_ctl got %b want 0", ctl()); end
      total++;
      if (bus.instret !== '0) begin bad++; $display("FAIL reset_instret got %0d want 0", bus.instret); end
      total++;
      if (bus.trap !== 1'b0 || bus.trap_cause !== 2'd0) begin
         bad++; $display("FAIL reset_trap got %b/%0d want 0/0", bus.trap, bus.trap_cause);
      end
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      model_instret = '0;
   endtask

   task automatic test_op;
      logic [9:0] got, exp;
      int c = 0;
      push_instr(OPC_OP, 3'b000, 1'b0, 0, 0);
      push(1'b0, 1'b0, 1'b0, OPC_OP, 3'b000, 10'b1000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL op c%0d got %b want %b", c, got, exp); end
         if (c == 3) begin
            total++;
            if (bus.instret !== model_instret) begin bad++; $display("FAIL op_instret got %0d want %0d", bus.instret, model_instret); end
         end
         c++;
      end
   endtask

   task automatic test_load_stall;
      logic [9:0] got, exp;
      int c = 0;
      push_instr(OPC_LOAD, 3'b010, 1'b0, 0, 3);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL load c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.instret !== model_instret) begin bad++; $display("FAIL load_instret got %0d want %0d", bus.instret, model_instret); end
   endtask

   task automatic test_store;
      logic [9:0] got, exp;
      int c = 0;
      push_instr(OPC_STORE, 3'b010, 1'b0, 0, 0);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL store c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.instret !== model_instret) begin bad++; $display("FAIL store_instret got %0d want %0d", bus.instret, model_instret); end
   endtask

   task automatic test_branch;
      logic [9:0] got, exp;
      int c = 0;
      push_instr(OPC_BRANCH, 3'b000, 1'b1, 0, 0);
      push_instr(OPC_BRANCH, 3'b001, 1'b0, 0, 0);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL branch c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.instret !== model_instret) begin bad++; $display("FAIL branch_instret got %0d want %0d", bus.instret, model_instret); end
   endtask

   // Mixed stream with fetch and memory waits on the same instruction; instret wraps at 2^IW.
   task automatic test_back_to_back;
      logic [9:0] got, exp;
      int c = 0;
      for (int i = 0; i < 12; i++) begin
         case (i % 4)
            0:       push_instr(OPC_OP_IMM, 3'(i), 1'b0, i / 4, 0);
            1:       push_instr(OPC_BRANCH, 3'b000, 1'((i / 4) % 2), 0, 0);
            2:       push_instr(OPC_STORE, 3'b010, 1'b0, 3, 3);
            default: push_instr(OPC_LOAD, 3'b010, 1'b0, 1, 1);
         endcase
      end
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL b2b c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.instret !== model_instret) begin bad++; $display("FAIL b2b_instret got %0d want %0d", bus.instret, model_instret); end
      total++;
      if (bus.trap !== 1'b0) begin bad++; $display("FAIL b2b_trap got %b want 0", bus.trap); end
   endtask

   task automatic test_illegal;
      logic [9:0] got, exp;
      int c = 0;
      do_reset();
      push_instr(OPC_OP, 3'b000, 1'b0, 0, 0);
      push(1'b1, 1'b0, 1'b0, 7'b1111111, 3'b000, 10'b1100000000);
      push(1'b0, 1'b0, 1'b0, 7'b1111111, 3'b000, 10'b0000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL illegal c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b1 || bus.trap_cause !== 2'd1) begin
         bad++; $display("FAIL illegal_trap got %b/%0d want 1/1", bus.trap, bus.trap_cause);
      end
      for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b1, OPC_OP, 3'b000, 10'b0000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL illegal_sticky c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b1 || bus.trap_cause !== 2'd1 || bus.instret !== model_instret) begin
         bad++; $display("FAIL illegal_hold got %b/%0d/%0d want 1/1/%0d", bus.trap, bus.trap_cause, bus.instret, model_instret);
      end
      do_reset();
      push(1'b1, 1'b0, 1'b0, OPC_LOAD, 3'b000, 10'b1100000000);
      push(1'b0, 1'b0, 1'b0, OPC_LOAD, 3'b000, 10'b0000000000);
      push(1'b1, 1'b1, 1'b0, OPC_LOAD, 3'b000, 10'b0000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL lb_illegal c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b1 || bus.trap_cause !== 2'd1 || bus.instret !== '0) begin
         bad++; $display("FAIL lb_illegal_trap got %b/%0d/%0d want 1/1/0", bus.trap, bus.trap_cause, bus.instret);
      end
   endtask

   task automatic test_imem_timeout;
      logic [9:0] got, exp;
      int c = 0;
      do_reset();
      for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, 1'b0, OPC_OP, 3'b000, 10'b1000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL itmo c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b0) begin bad++; $display("FAIL itmo_early got %b want 0", bus.trap); end
      push(1'b0, 1'b0, 1'b0, OPC_OP, 3'b000, 10'b1000000000);
      push(1'b1, 1'b1, 1'b0, OPC_OP, 3'b000, 10'b0000000000);
      push(1'b1, 1'b1, 1'b0, OPC_OP, 3'b000, 10'b0000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL itmo c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b1 || bus.trap_cause !== 2'd2) begin
         bad++; $display("FAIL itmo_trap got %b/%0d want 1/2", bus.trap, bus.trap_cause);
      end
   endtask

   task automatic test_imem_limit_ready;
      logic [9:0] got, exp;
      int c = 0;
      do_reset();
      push_instr(OPC_OP, 3'b000, 1'b0, TMO, 0);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL ilimit c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b0 || bus.instret !== model_instret) begin
         bad++; $display("FAIL ilimit_state got %b/%0d want 0/%0d", bus.trap, bus.instret, model_instret);
      end
   endtask

   task automatic test_dmem_timeout;
      logic [9:0] got, exp;
      int c = 0;
      do_reset();
      push(1'b1, 1'b0, 1'b0, OPC_STORE, 3'b010, 10'b1100000000);
      push(1'b0, 1'b0, 1'b0, OPC_STORE, 3'b010, 10'b0000000000);
      push(1'b0, 1'b0, 1'b0, OPC_STORE, 3'b010, 10'b0000010000);
      for (int i = 0; i <= TMO; i++) push(1'b0, 1'b0, 1'b0, OPC_STORE, 3'b010, 10'b0011010000);
      push(1'b1, 1'b1, 1'b0, OPC_STORE, 3'b010, 10'b0000000000);
      push(1'b1, 1'b1, 1'b0, OPC_STORE, 3'b010, 10'b0000000000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL dtmo c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.trap !== 1'b1 || bus.trap_cause !== 2'd3 || bus.instret !== '0) begin
         bad++; $display("FAIL dtmo_trap got %b/%0d/%0d want 1/3/0", bus.trap, bus.trap_cause, bus.instret);
      end
   endtask

   task automatic test_reset_mid;
      logic [9:0] got, exp;
      int c = 0;
      do_reset();
      push_instr(OPC_OP, 3'b000, 1'b0, 0, 0);
      push(1'b1, 1'b0, 1'b0, OPC_LOAD, 3'b010, 10'b1100000000);
      push(1'b0, 1'b0, 1'b0, OPC_LOAD, 3'b010, 10'b0000000000);
      push(1'b0, 1'b0, 1'b0, OPC_LOAD, 3'b010, 10'b0000010000);
      push(1'b0, 1'b0, 1'b0, OPC_LOAD, 3'b010, 10'b0010010000);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL rmid c%0d got %b want %b", c, got, exp); end
         c++;
      end
      bus.dmem_ready = 1'b1;
      rst_n          = 1'b0;
      #1;
      total++;
      if (ctl() !== 10'd0) begin bad++; $display("FAIL rmid_ctl got %b want 0", ctl()); end
      total++;
      if (bus.instret !== '0 || bus.trap !== 1'b0) begin
         bad++; $display("FAIL rmid_state got %0d/%b want 0/0", bus.instret, bus.trap);
      end
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      model_instret = '0;
      push_instr(OPC_OP_IMM, 3'b000, 1'b0, 0, 0);
      while (exp_q.size() > 0) begin
         next_cycle(got, exp);
         total++;
         if (got !== exp) begin bad++; $display("FAIL rmid_after c%0d got %b want %b", c, got, exp); end
         c++;
      end
      total++;
      if (bus.instret !== model_instret) begin bad++; $display("FAIL rmid_instret got %0d want %0d", bus.instret, model_instret); end
   endtask

   initial begin
      bus.imem_ready   = 1'b0;
      bus.dmem_ready   = 1'b0;
      bus.branch_taken = 1'b0;
      bus.opcode       = 7'd0;
      bus.funct3       = 3'd0;
      test_reset();
      test_op();
      test_load_stall();
      test_store();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_imem_timeout();
      test_imem_limit_ready();
      test_dmem_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
